uart_move_link: RTL and testbench

//  Game-side initiator for the UART transaction wrapper (uart_en/uart_mode/rx_tx_done handshake).

---
 rtl/tictac_link_pkg.sv | 37 +++
 rtl/link_timer.sv | 37 +++
 rtl/uart_move_link.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_move_link.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tictac_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : tictac_link_pkg
//  Purpose : Shared constants, FSM state type and frame helpers for the
//            tic-tac-toe move link (frame = {SYNC_HDR, sym, pos[3:0]}).
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package tictac_link_pkg;

  localparam logic [2:0] SYNC_HDR = 3'b101;
  localparam logic [3:0] MAX_POS  = 4'd8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TX       = 3'd1,
    TX_GAP   = 3'd2,
    RX       = 3'd3,
    RX_GAP   = 3'd4,
    RX_RETRY = 3'd5
  } link_state_t;

  // Build the on-wire byte for a move.
  function automatic logic [7:0] frame_enc(input logic sym, input logic [3:0] pos);
    return {SYNC_HDR, sym, pos};
  endfunction

  // A received move is only legal if it carries the sync header, names a
  // board cell, and was made by the opponent (the other symbol).
  function automatic logic frame_ok(input logic [7:0] rx_byte, input logic local_sym);
    return (rx_byte[7:5] == SYNC_HDR) &&
           (rx_byte[3:0] <= MAX_POS) &&
           (rx_byte[4] == ~local_sym);
  endfunction

endpackage : tictac_link_pkg
`default_nettype wire

// File: rtl/link_timer.sv
`default_nettype none
// ============================================================================
//  Module  : link_timer
//  Purpose : Free-running up counter with synchronous clear and count enable;
//            flags when the count equals a terminal value.
//  Ports   : clk, reset      - clock, synchronous active-high reset
//            clear           - force count to 0 (wins over enable)
//            enable          - advance count by one
//            limit [CNT_W]   - terminal count value
//            tc              - count == limit
//  Rev     : 1.0  initial release
// ============================================================================
module link_timer #(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tc = (r_cnt == limit);

endmodule : link_timer
`default_nettype wire

// File: rtl/uart_move_link.sv
`default_nettype none
// ============================================================================
//  Module  : uart_move_link
//  Purpose : Game-side initiator for the UART transaction wrapper. Sends the
//            local move as one framed byte, receives and validates the
//            opponent's move, reports framing errors and receive timeout.
//  Ports   : clk, reset                  - clock, sync active-high reset
//            send_req, recv_req          - request pulses from game FSM
//            move_pos[4], local_sym      - local move / symbol
//            uart_en, uart_mode,
//            uart_wdata[8]               - wrapper request (registered)
//            uart_done, uart_rdata[8]    - wrapper completion / rx byte
//            busy                        - not IDLE
//            sent, rx_valid, err_frame,
//            timeout                     - one-cycle result pulses
//            rx_pos[4], rx_sym           - last valid opponent move
//  Rev     : 1.0  initial release
// ============================================================================
module uart_move_link
  import tictac_link_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 200_000_000,
  parameter int          CNT_W          = 28,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send_req,
  input  logic       recv_req,
  input  logic [3:0] move_pos,
  input  logic       local_sym,
  output logic       uart_en,
  output logic       uart_mode,
  output logic [7:0] uart_wdata,
  input  logic       uart_done,
  input  logic [7:0] uart_rdata,
  output logic       busy,
  output logic       sent,
  output logic       rx_valid,
  output logic [3:0] rx_pos,
  output logic       rx_sym,
  output logic       err_frame,
  output logic       timeout
);

  localparam bit                c_tmo_on   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0]  c_tmo_last = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam int                c_gap_w    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYCLES - 1);

  link_state_t        r_state, w_state_nxt;
  logic [c_gap_w-1:0] r_gap_cnt, w_gap_nxt;

  logic       r_uart_en, w_en_nxt;
  logic       r_uart_mode, w_mode_nxt;
  logic [7:0] r_uart_wdata, w_wdata_nxt;
  logic       r_busy;
  logic       r_sent, w_sent_nxt;
  logic       r_rx_valid, w_rx_valid_nxt;
  logic [3:0] r_rx_pos, w_rx_pos_nxt;
  logic       r_rx_sym, w_rx_sym_nxt;
  logic       r_err_frame, w_err_nxt;
  logic       r_timeout, w_timeout_nxt;

  logic w_tmr_clr, w_tmr_en, w_tmr_tc, w_tmo_hit, w_gap_last;

  link_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_tmr_clr),
    .enable (w_tmr_en),
    .limit  (c_tmo_last),
    .tc     (w_tmr_tc)
  );

  // TIMEOUT_CYCLES of 0 disables the receive timeout entirely.
  assign w_tmo_hit  = c_tmo_on && w_tmr_tc;
  assign w_gap_last = (r_gap_cnt == c_gap_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_gap_cnt    <= '0;
      r_uart_en    <= 1'b0;
      r_uart_mode  <= 1'b0;
      r_uart_wdata <= 8'h00;
      r_busy       <= 1'b0;
      r_sent       <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_rx_pos     <= 4'd0;
      r_rx_sym     <= 1'b0;
      r_err_frame  <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_gap_cnt    <= w_gap_nxt;
      r_uart_en    <= w_en_nxt;
      r_uart_mode  <= w_mode_nxt;
      r_uart_wdata <= w_wdata_nxt;
      r_busy       <= (w_state_nxt != IDLE);
      r_sent       <= w_sent_nxt;
      r_rx_valid   <= w_rx_valid_nxt;
      r_rx_pos     <= w_rx_pos_nxt;
      r_rx_sym     <= w_rx_sym_nxt;
      r_err_frame  <= w_err_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gap_nxt      = '0;
    w_en_nxt       = r_uart_en;
    w_mode_nxt     = r_uart_mode;
    w_wdata_nxt    = r_uart_wdata;
    w_rx_pos_nxt   = r_rx_pos;
    w_rx_sym_nxt   = r_rx_sym;
    w_sent_nxt     = 1'b0;
    w_rx_valid_nxt = 1'b0;
    w_err_nxt      = 1'b0;
    w_timeout_nxt  = 1'b0;
    w_tmr_clr      = 1'b0;
    w_tmr_en       = 1'b0;

    case (r_state)
      IDLE: begin
        if (send_req) begin
          w_state_nxt = TX;
          w_wdata_nxt = frame_enc(local_sym, move_pos);
          w_mode_nxt  = 1'b0;
          w_en_nxt    = 1'b1;
        end else if (recv_req) begin
          w_state_nxt = RX;
          w_mode_nxt  = 1'b1;
          w_en_nxt    = 1'b1;
          w_tmr_clr   = 1'b1;
        end
      end

      TX: begin
        if (uart_done) begin
          w_en_nxt    = 1'b0;
          w_state_nxt = TX_GAP;
        end
      end

      TX_GAP: begin
        w_gap_nxt = r_gap_cnt + 1'b1;
        if (w_gap_last) begin
          w_gap_nxt   = '0;
          w_sent_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end

      RX: begin
        w_tmr_en = 1'b1;
        // A byte arriving in the terminal cycle still counts.
        if (uart_done) begin
          w_en_nxt = 1'b0;
          if (frame_ok(uart_rdata, local_sym)) begin
            w_rx_pos_nxt   = uart_rdata[3:0];
            w_rx_sym_nxt   = uart_rdata[4];
            w_rx_valid_nxt = 1'b1;
            w_state_nxt    = RX_GAP;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = RX_RETRY;
          end
        end else if (w_tmo_hit) begin
          w_en_nxt      = 1'b0;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = IDLE;
        end
      end

      RX_GAP: begin
        w_gap_nxt = r_gap_cnt + 1'b1;
        if (w_gap_last) begin
          w_gap_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end

      RX_RETRY: begin
        // The timeout budget spans all retries of one receive request.
        w_tmr_en  = 1'b1;
        w_gap_nxt = r_gap_cnt + 1'b1;
        if (w_tmo_hit) begin
          w_gap_nxt     = '0;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = IDLE;
        end else if (w_gap_last) begin
          w_gap_nxt   = '0;
          w_en_nxt    = 1'b1;
          w_mode_nxt  = 1'b1;
          w_state_nxt = RX;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_en_nxt    = 1'b0;
      end
    endcase
  end

  assign uart_en    = r_uart_en;
  assign uart_mode  = r_uart_mode;
  assign uart_wdata = r_uart_wdata;
  assign busy       = r_busy;
  assign sent       = r_sent;
  assign rx_valid   = r_rx_valid;
  assign rx_pos     = r_rx_pos;
  assign rx_sym     = r_rx_sym;
  assign err_frame  = r_err_frame;
  assign timeout    = r_timeout;

endmodule : uart_move_link
`default_nettype wire

// File: tb/tb_uart_move_link.sv
`default_nettype none
// ============================================================================
//  Module  : tb_uart_move_link
//  Purpose : Self-checking bench for uart_move_link: directed scenarios plus
//            randomized send/receive traffic against a behavioural model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_uart_move_link;

  localparam int TMO = 50;
  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       send_req, recv_req, local_sym, uart_done;
  logic [3:0] move_pos;
  logic [7:0] uart_rdata;
  logic       uart_en, uart_mode, busy, sent, rx_valid, rx_sym, err_frame, timeout;
  logic [7:0] uart_wdata;
  logic [3:0] rx_pos;

  int vectors     = 0;
  int miscompares = 0;

  // Model of the held receive result.
  int m_pos = 0;
  int m_sym = 0;

  uart_move_link #(
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (8),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .send_req   (send_req),
    .recv_req   (recv_req),
    .move_pos   (move_pos),
    .local_sym  (local_sym),
    .uart_en    (uart_en),
    .uart_mode  (uart_mode),
    .uart_wdata (uart_wdata),
    .uart_done  (uart_done),
    .uart_rdata (uart_rdata),
    .busy       (busy),
    .sent       (sent),
    .rx_valid   (rx_valid),
    .rx_pos     (rx_pos),
    .rx_sym     (rx_sym),
    .err_frame  (err_frame),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference rules, written arithmetically from the frame definition.
  function automatic int model_frame(input int sym, input int pos);
    return 160 + 16 * sym + pos;
  endfunction

  function automatic bit model_valid(input int b, input int ls);
    return (b / 32 == 5) && (b % 16 <= 8) && (((b / 16) % 2) != ls);
  endfunction

  // Full transmit: request, done after 'dly' cycles in TX, gap, sent pulse.
  task automatic do_send(input int pos, input int sym, input int dly);
    send_req = 1'b1; move_pos = 4'(pos); local_sym = sym[0];
    tick();
    send_req = 1'b0;
    chk("tx_en",    32'(uart_en), 1);
    chk("tx_mode",  32'(uart_mode), 0);
    chk("tx_wdata", 32'(uart_wdata), 32'(model_frame(sym, pos)));
    chk("tx_busy",  32'(busy), 1);
    for (int i = 0; i < dly; i++) tick();
    chk("tx_hold_en", 32'(uart_en), 1);
    uart_done = 1'b1;
    tick();
    uart_done = 1'b0;
    chk("tx_en_drop", 32'(uart_en), 0);
    for (int i = 1; i <= GAP; i++) begin
      tick();
      if (i < GAP) chk("tx_gap_sent", 32'(sent), 0);
    end
    chk("tx_sent", 32'(sent), 1);
    chk("tx_busy_fall", 32'(busy), 0);
    tick();
    chk("tx_sent_once", 32'(sent), 0);
  endtask

  task automatic start_recv(input int ls);
    recv_req = 1'b1; local_sym = ls[0];
    tick();
    recv_req = 1'b0;
    chk("rx_en",   32'(uart_en), 1);
    chk("rx_mode", 32'(uart_mode), 1);
    chk("rx_busy", 32'(busy), 1);
  endtask

  // Deliver one byte while in RX with en high; afterwards the link is either
  // IDLE (valid byte) or back in RX with en high (rejected byte).
  task automatic recv_byte(input int b, input int dly);
    bit ok;
    ok = model_valid(b, int'(local_sym));
    for (int i = 0; i < dly; i++) tick();
    uart_done = 1'b1; uart_rdata = 8'(b);
    tick();
    uart_done = 1'b0;
    chk("rxb_en_drop", 32'(uart_en), 0);
    chk("rxb_timeout", 32'(timeout), 0);
    chk("rxb_valid",   32'(rx_valid), 32'(ok));
    chk("rxb_err",     32'(err_frame), 32'(!ok));
    if (ok) begin
      m_pos = b % 16;
      m_sym = (b / 16) % 2;
    end
    chk("rxb_pos", 32'(rx_pos), 32'(m_pos));
    chk("rxb_sym", 32'(rx_sym), 32'(m_sym));
    for (int i = 1; i <= GAP; i++) begin
      tick();
      if (i < GAP) chk("rxb_gap_en", 32'(uart_en), 0);
    end
    if (ok) begin
      chk("rxb_idle_busy", 32'(busy), 0);
      chk("rxb_idle_en",   32'(uart_en), 0);
    end else begin
      chk("rxb_retry_en",   32'(uart_en), 1);
      chk("rxb_retry_mode", 32'(uart_mode), 1);
      chk("rxb_retry_busy", 32'(busy), 1);
    end
  endtask

  initial begin
    int seen;
    int b;
    reset = 1'b1; send_req = 1'b0; recv_req = 1'b0; move_pos = 4'd0;
    local_sym = 1'b0; uart_done = 1'b0; uart_rdata = 8'h00;
    tick(); tick();
    chk("rst_en",    32'(uart_en), 0);
    chk("rst_mode",  32'(uart_mode), 0);
    chk("rst_wdata", 32'(uart_wdata), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_pos",   32'(rx_pos), 0);
    chk("rst_sym",   32'(rx_sym), 0);
    reset = 1'b0;
    tick();

    // Directed transmit: pos 4, X -> 0xA4.
    do_send(4, 0, 4);

    // Directed receive of 0xB7 by X.
    start_recv(0);
    recv_byte(8'hB7, 2);

    // Three rejected bytes, then a good one.
    start_recv(0);
    recv_byte(8'hA7, 1);
    recv_byte(8'hBC, 0);
    recv_byte(8'h37, 1);
    recv_byte(8'hB0, 0);

    // Timeout exactly TMO cycles after RX entry.
    start_recv(1);
    seen = 0;
    for (int i = 1; i < TMO; i++) begin
      tick();
      if (timeout) seen++;
    end
    chk("tmo_early", 32'(seen), 0);
    tick();
    chk("tmo_pulse", 32'(timeout), 1);
    chk("tmo_en",    32'(uart_en), 0);
    chk("tmo_busy",  32'(busy), 0);
    tick();
    chk("tmo_once",  32'(timeout), 0);

    // Done in the terminal cycle wins over timeout.
    start_recv(1);
    recv_byte(8'hA3, TMO - 1);

    // Simultaneous requests: transmit only.
    send_req = 1'b1; recv_req = 1'b1; move_pos = 4'd8; local_sym = 1'b1;
    tick();
    send_req = 1'b0; recv_req = 1'b0;
    chk("both_mode",  32'(uart_mode), 0);
    chk("both_wdata", 32'(uart_wdata), 32'(model_frame(1, 8)));
    uart_done = 1'b1;
    tick();
    uart_done = 1'b0;
    for (int i = 0; i < GAP; i++) tick();
    chk("both_sent", 32'(sent), 1);
    tick();

    // send_req during RX is ignored.
    start_recv(0);
    send_req = 1'b1; move_pos = 4'd1;
    tick();
    send_req = 1'b0;
    chk("ign_mode",  32'(uart_mode), 1);
    chk("ign_wdata", 32'(uart_wdata), 32'(model_frame(1, 8)));
    recv_byte(8'hB5, 1);

    // uart_done in IDLE is ignored.
    uart_done = 1'b1; uart_rdata = 8'hB2;
    tick();
    uart_done = 1'b0;
    tick();
    chk("idle_done_busy",  32'(busy), 0);
    chk("idle_done_valid", 32'(rx_valid), 0);
    chk("idle_done_pos",   32'(rx_pos), 32'(m_pos));

    // Reset in the middle of a transmit.
    send_req = 1'b1; move_pos = 4'd2; local_sym = 1'b0;
    tick();
    send_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_pos = 0; m_sym = 0;
    chk("mrst_en",    32'(uart_en), 0);
    chk("mrst_busy",  32'(busy), 0);
    chk("mrst_wdata", 32'(uart_wdata), 0);
    chk("mrst_pos",   32'(rx_pos), 0);
    uart_done = 1'b1;
    tick();
    uart_done = 1'b0;
    seen = 0;
    for (int i = 0; i < GAP + 3; i++) begin
      tick();
      if (sent || rx_valid || err_frame) seen++;
    end
    chk("mrst_no_pulse", 32'(seen), 0);

    // Randomized traffic. Per receive, at most 4 attempts of <=6 cycles each,
    // which stays well inside the timeout budget.
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_send(int'($urandom_range(0, 8)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 5)));
      end else begin
        start_recv(int'($urandom_range(0, 1)));
        for (int a = 0; a < 4; a++) begin
          if (a == 3 || $urandom_range(0, 1) == 0)
            b = model_frame(1 - int'(local_sym), int'($urandom_range(0, 8)));
          else
            b = int'($urandom_range(0, 255));
          recv_byte(b, int'($urandom_range(0, 3)));
          if (model_valid(b, int'(local_sym))) break;
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_uart_move_link
`default_nettype wire
